gps_ca_code_gen: RTL and testbench

- Consumer of the 1.023 MHz chip clock produced by the team's code NCO. Generates the GPS L1 C/A Gold code: 1023-chip sequence per PRN, a chip counter and a 1 ms epoch pulse.
- Runs on the same system clock as the NCO. The chip clock input is a same-domain, registered toggle signal.
- Each rising edge of the chip clock advances the code by one chip.
- A PRN change requested mid-epoch is deferred to the next epoch boundary.

---
 rtl/gps_ca_code_gen_if.sv | 34 +++
 rtl/gps_ca_code_gen.sv | 173 +++++++++++++++++
 tb/tb_gps_ca_code_gen.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gps_ca_code_gen_if.sv
// Control/status bundle for the GPS L1 C/A code generator.
// Optional nav-bit timing signals exist only when CA_NAV_BIT_EN is defined.
interface gps_ca_code_gen_if;
  logic       clk_ca_1023;
  logic       en;
  logic [5:0] prn_sel;
  logic       prn_load;
  logic       ca_chip;
  logic       chip_strobe;
  logic [9:0] chip_cnt;
  logic       epoch;
  logic [5:0] prn_active;
  logic       prn_pending;
`ifdef CA_NAV_BIT_EN
  logic [4:0] nav_ms_cnt;
  logic       nav_bit_edge;
`endif

  modport master (
    output clk_ca_1023, en, prn_sel, prn_load,
`ifdef CA_NAV_BIT_EN
    input  nav_ms_cnt, nav_bit_edge,
`endif
    input  ca_chip, chip_strobe, chip_cnt, epoch, prn_active, prn_pending
  );

  modport slave (
    input  clk_ca_1023, en, prn_sel, prn_load,
`ifdef CA_NAV_BIT_EN
    output nav_ms_cnt, nav_bit_edge,
`endif
    output ca_chip, chip_strobe, chip_cnt, epoch, prn_active, prn_pending
  );
endinterface

// File: rtl/gps_ca_code_gen.sv
// GPS L1 C/A Gold code generator: G1/G2 LFSRs, chip counter, 1 ms epoch, deferred PRN switch.
// Define CA_NAV_BIT_EN to add the 20 ms nav-bit counter (nav_ms_cnt / nav_bit_edge).
module gps_ca_code_gen #(
  parameter int unsigned DEFAULT_PRN = 1,
  parameter int unsigned CHIP_MAX    = 1022
) (
  input  logic              clkin,
  input  logic              rst,
  gps_ca_code_gen_if.slave  bus
);

  // G2 phase-select taps (t1,t2) per PRN
  function automatic logic [7:0] taps(input logic [5:0] prn);
    case (prn)
      6'd1:  taps = {4'd2, 4'd6};
      6'd2:  taps = {4'd3, 4'd7};
      6'd3:  taps = {4'd4, 4'd8};
      6'd4:  taps = {4'd5, 4'd9};
      6'd5:  taps = {4'd1, 4'd9};
      6'd6:  taps = {4'd2, 4'd10};
      6'd7:  taps = {4'd1, 4'd8};
      6'd8:  taps = {4'd2, 4'd9};
      6'd9:  taps = {4'd3, 4'd10};
      6'd10: taps = {4'd2, 4'd3};
      6'd11: taps = {4'd3, 4'd4};
      6'd12: taps = {4'd5, 4'd6};
      6'd13: taps = {4'd6, 4'd7};
      6'd14: taps = {4'd7, 4'd8};
      6'd15: taps = {4'd8, 4'd9};
      6'd16: taps = {4'd9, 4'd10};
      6'd17: taps = {4'd1, 4'd4};
      6'd18: taps = {4'd2, 4'd5};
      6'd19: taps = {4'd3, 4'd6};
      6'd20: taps = {4'd4, 4'd7};
      6'd21: taps = {4'd5, 4'd8};
      6'd22: taps = {4'd6, 4'd9};
      6'd23: taps = {4'd1, 4'd3};
      6'd24: taps = {4'd4, 4'd6};
      6'd25: taps = {4'd5, 4'd7};
      6'd26: taps = {4'd6, 4'd8};
      6'd27: taps = {4'd7, 4'd9};
      6'd28: taps = {4'd8, 4'd10};
      6'd29: taps = {4'd1, 4'd6};
      6'd30: taps = {4'd2, 4'd7};
      6'd31: taps = {4'd3, 4'd8};
      6'd32: taps = {4'd4, 4'd9};
      default: taps = {4'd2, 4'd6};
    endcase
  endfunction

  function automatic logic ca_fn(input logic [10:1] g1, input logic [10:1] g2,
                                 input logic [5:0] prn);
    logic [7:0] t;
    t = taps(prn);
    ca_fn = g1[10] ^ g2[t[7:4]] ^ g2[t[3:0]];
  endfunction

  logic [10:1] g1_q, g1_d, g2_q, g2_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [5:0]  prn_q, prn_d, pprn_q, pprn_d;
  logic        pend_q, pend_d;
  logic        ca_q, ca_d;
  logic        stb_q, stb_d;
  logic        ep_q, ep_d;
  logic        ce_q;
  logic        chip_edge, wrap, ld_ok;

  assign chip_edge = bus.clk_ca_1023 & ~ce_q & bus.en;
  assign wrap      = chip_edge && (cnt_q == 10'(CHIP_MAX));
  assign ld_ok     = bus.prn_load && (bus.prn_sel >= 6'd1) && (bus.prn_sel <= 6'd32);

  always_comb begin
    g1_d   = g1_q;
    g2_d   = g2_q;
    cnt_d  = cnt_q;
    prn_d  = prn_q;
    pend_d = pend_q;
    pprn_d = pprn_q;
    ca_d   = ca_q;
    stb_d  = 1'b0;
    ep_d   = 1'b0;
    if (chip_edge) begin
      stb_d = 1'b1;
      if (wrap) begin
        g1_d  = 10'h3FF;
        g2_d  = 10'h3FF;
        cnt_d = 10'd0;
        ep_d  = 1'b1;
        if (pend_q) prn_d = pprn_q;
      end else begin
        g1_d  = {g1_q[9:1], g1_q[3] ^ g1_q[10]};
        g2_d  = {g2_q[9:1], g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^ g2_q[9] ^ g2_q[10]};
        cnt_d = cnt_q + 10'd1;
      end
      ca_d = ca_fn(g1_d, g2_d, prn_d);
    end
    // a load arriving with the wrap is kept for the following epoch
    if (ld_ok) begin
      pend_d = 1'b1;
      pprn_d = bus.prn_sel;
    end else if (wrap) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      g1_q   <= 10'h3FF;
      g2_q   <= 10'h3FF;
      cnt_q  <= 10'd0;
      prn_q  <= 6'(DEFAULT_PRN);
      pprn_q <= 6'(DEFAULT_PRN);
      pend_q <= 1'b0;
      ca_q   <= 1'b1;
      stb_q  <= 1'b0;
      ep_q   <= 1'b0;
      ce_q   <= 1'b0;
    end else begin
      g1_q   <= g1_d;
      g2_q   <= g2_d;
      cnt_q  <= cnt_d;
      prn_q  <= prn_d;
      pprn_q <= pprn_d;
      pend_q <= pend_d;
      ca_q   <= ca_d;
      stb_q  <= stb_d;
      ep_q   <= ep_d;
      ce_q   <= bus.clk_ca_1023;
    end
  end

  assign bus.ca_chip     = ca_q;
  assign bus.chip_strobe = stb_q;
  assign bus.chip_cnt    = cnt_q;
  assign bus.epoch       = ep_q;
  assign bus.prn_active  = prn_q;
  assign bus.prn_pending = pend_q;

`ifdef CA_NAV_BIT_EN
  logic [4:0] nav_q, nav_d;
  logic       nedge_q, nedge_d;

  // a PRN switch restarts nav-bit timing without flagging a bit edge
  always_comb begin
    nav_d   = nav_q;
    nedge_d = 1'b0;
    if (wrap) begin
      if (pend_q) begin
        nav_d = 5'd0;
      end else if (nav_q == 5'd19) begin
        nav_d   = 5'd0;
        nedge_d = 1'b1;
      end else begin
        nav_d = nav_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      nav_q   <= 5'd0;
      nedge_q <= 1'b0;
    end else begin
      nav_q   <= nav_d;
      nedge_q <= nedge_d;
    end
  end

  assign bus.nav_ms_cnt   = nav_q;
  assign bus.nav_bit_edge = nedge_q;
`endif

endmodule

// File: tb/tb_gps_ca_code_gen.sv
// Directed bench for gps_ca_code_gen with a chip-level scoreboard fed by a reference LFSR model.
module tb_gps_ca_code_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gps_ca_code_gen_if bus();
  gps_ca_code_gen #(.DEFAULT_PRN(1), .CHIP_MAX(1022)) dut (.clkin(clk), .rst(rst_n), .bus(bus));

  typedef struct packed {
    logic       ca;
    logic [9:0] cnt;
    logic       ep;
    logic [5:0] prn;
    logic       pend;
    logic [4:0] nav;
    logic       ne;
  } exp_t;

  exp_t sbq[$];
  int n_cmp = 0;
  int n_bad = 0;

  int t1_tab[1:32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
  int t2_tab[1:32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

  logic [10:1] m_g1, m_g2;
  int m_cnt, m_prn, m_pend, m_pprn, m_nav;
  logic [9:0] pat1, pat2;
  int frz_cnt;
  logic frz_ca;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic m_reset();
    m_g1 = '1; m_g2 = '1; m_cnt = 0; m_prn = 1; m_pend = 0; m_pprn = 1; m_nav = 0;
  endtask

  function automatic logic m_ca();
    return m_g1[10] ^ m_g2[t1_tab[m_prn]] ^ m_g2[t2_tab[m_prn]];
  endfunction

  task automatic m_load(input int sel);
    if (sel >= 1 && sel <= 32) begin m_pend = 1; m_pprn = sel; end
  endtask

  task automatic m_step(input bit ld, input int sel);
    exp_t e;
    bit sw = 0;
    bit ne = 0;
    if (m_cnt == 1022) begin
      m_g1 = '1; m_g2 = '1; m_cnt = 0;
      if (m_pend != 0) begin m_prn = m_pprn; m_pend = 0; sw = 1; end
      if (sw) m_nav = 0;
      else if (m_nav == 19) begin m_nav = 0; ne = 1; end
      else m_nav++;
    end else begin
      m_g1 = {m_g1[9:1], m_g1[3] ^ m_g1[10]};
      m_g2 = {m_g2[9:1], ^{m_g2[2], m_g2[3], m_g2[6], m_g2[8], m_g2[9], m_g2[10]}};
      m_cnt++;
    end
    if (ld) m_load(sel);
    e.ca = m_ca(); e.cnt = 10'(m_cnt); e.ep = (m_cnt == 0); e.prn = 6'(m_prn);
    e.pend = (m_pend != 0); e.nav = 5'(m_nav); e.ne = ne;
    sbq.push_back(e);
  endtask

  // one rising chip edge; returns on the cycle the DUT shows the new chip
  task automatic chip(input bit ld = 0, input logic [5:0] sel = 6'd0);
    @(negedge clk);
    bus.clk_ca_1023 = 1'b1; bus.prn_load = ld; bus.prn_sel = sel;
    if (bus.en) m_step(ld, int'(sel));
    @(negedge clk);
    bus.clk_ca_1023 = 1'b0; bus.prn_load = 1'b0;
  endtask

  task automatic load(input logic [5:0] sel);
    @(negedge clk);
    bus.prn_load = 1'b1; bus.prn_sel = sel;
    m_load(int'(sel));
    @(negedge clk);
    bus.prn_load = 1'b0;
  endtask

  task automatic run_to(input int tgt);
    for (int i = 0; i < 1100 && m_cnt != tgt; i++) chip();
    chk("run_to_cnt", bus.chip_cnt, tgt);
  endtask

  // scoreboard consumer: every strobe must match the next queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.chip_strobe) begin
        chk("sb_has_entry", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("sb_ca",   bus.ca_chip,     e.ca);
          chk("sb_cnt",  bus.chip_cnt,    e.cnt);
          chk("sb_ep",   bus.epoch,       e.ep);
          chk("sb_prn",  bus.prn_active,  e.prn);
          chk("sb_pend", bus.prn_pending, e.pend);
`ifdef CA_NAV_BIT_EN
          chk("sb_nav",  bus.nav_ms_cnt,   e.nav);
          chk("sb_ne",   bus.nav_bit_edge, e.ne);
`endif
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pat1 = 10'o1440;
    pat2 = 10'o1620;
    bus.clk_ca_1023 = 1'b0; bus.en = 1'b1; bus.prn_sel = 6'd0; bus.prn_load = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_ca",   bus.ca_chip, 1);
    chk("rst_stb",  bus.chip_strobe, 0);
    chk("rst_cnt",  bus.chip_cnt, 0);
    chk("rst_ep",   bus.epoch, 0);
    chk("rst_prn",  bus.prn_active, 1);
    chk("rst_pend", bus.prn_pending, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // PRN1 first chips: 1440 octal
    for (int k = 1; k < 10; k++) begin
      chip();
      chk("prn1_chip", bus.ca_chip, pat1[9-k]);
      chk("prn1_cnt", bus.chip_cnt, k);
    end
    run_to(1022);
    chip();
    chk("ep1_pulse", bus.epoch, 1);
    chk("ep1_ca", bus.ca_chip, 1);
    @(negedge clk);
    chk("ep1_single", bus.epoch, 0);
    for (int k = 1; k < 10; k++) begin
      chip();
      chk("prn1_rep", bus.ca_chip, pat1[9-k]);
    end

    // illegal PRN numbers are ignored
    load(6'd0);
    chk("ld0_pend", bus.prn_pending, 0);
    load(6'd40);
    chk("ld40_pend", bus.prn_pending, 0);
    chk("ld40_prn", bus.prn_active, 1);

    // last valid load before the epoch wins
    run_to(500);
    load(6'd5);
    load(6'd2);
    chk("ld2_pend", bus.prn_pending, 1);
    chk("ld2_prn_hold", bus.prn_active, 1);
    run_to(1022);
    chk("ld2_pend_late", bus.prn_pending, 1);
    chip();
    chk("ep2_prn", bus.prn_active, 2);
    chk("ep2_pend", bus.prn_pending, 0);
    chk("ep2_ca", bus.ca_chip, pat2[9]);
    for (int k = 1; k < 10; k++) begin
      chip();
      chk("prn2_chip", bus.ca_chip, pat2[9-k]);
    end

    // load coincident with the wrap waits one more epoch
    run_to(1022);
    chip(1'b1, 6'd3);
    chk("coin_ep", bus.epoch, 1);
    chk("coin_prn", bus.prn_active, 2);
    chk("coin_pend", bus.prn_pending, 1);
    run_to(1022);
    chip();
    chk("coin_prn_next", bus.prn_active, 3);
    chk("coin_pend_clr", bus.prn_pending, 0);

    // edges with en low are dropped
    run_to(100);
    frz_cnt = m_cnt;
    frz_ca  = m_ca();
    bus.en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chip();
      chk("en0_stb", bus.chip_strobe, 0);
      chk("en0_cnt", bus.chip_cnt, frz_cnt);
      chk("en0_ca",  bus.ca_chip, frz_ca);
    end
    bus.en = 1'b1;
    chip();
    chk("en1_cnt", bus.chip_cnt, frz_cnt + 1);

    // asynchronous reset mid-epoch discards the pending PRN
    run_to(700);
    load(6'd7);
    chk("prerst_pend", bus.prn_pending, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ca",   bus.ca_chip, 1);
    chk("arst_stb",  bus.chip_strobe, 0);
    chk("arst_cnt",  bus.chip_cnt, 0);
    chk("arst_ep",   bus.epoch, 0);
    chk("arst_prn",  bus.prn_active, 1);
    chk("arst_pend", bus.prn_pending, 0);
`ifdef CA_NAV_BIT_EN
    chk("arst_nav",  bus.nav_ms_cnt, 0);
    chk("arst_ne",   bus.nav_bit_edge, 0);
`endif
    sbq.delete();
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    chip();
    chk("postrst_cnt", bus.chip_cnt, 1);
    chk("postrst_ca", bus.ca_chip, pat1[8]);

`ifdef CA_NAV_BIT_EN
    for (int e = 1; e <= 40; e++) begin
      run_to(1022);
      chip();
      chk("nav_edge", bus.nav_bit_edge, (e % 20) == 0);
      chk("nav_cnt",  bus.nav_ms_cnt, e % 20);
    end
`endif

    @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
